// File: rtl/ddr_rd_arbiter_pkg.sv
// ddr_rd_arbiter shared types
// States, grant IDs and default widths.
package ddr_rd_arbiter_pkg;

    localparam int DDR_ADDR_WIDTH = 28;
    localparam int LEN_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_INS = 1'b0,
        GRANT_DAT = 1'b1
    } grant_e;

endpackage

// File: rtl/ddr_rd_arbiter_if.sv
// ddr_rd_arbiter bus bundle
// Cache request side plus DDR command/return side.
interface ddr_rd_arbiter_if
    import ddr_rd_arbiter_pkg::*;
#(
    parameter int AW = DDR_ADDR_WIDTH,
    parameter int LW = LEN_WIDTH
);
    logic          ins_read_req;
    logic [AW-1:0] ins_read_addr;
    logic [LW-1:0] ins_read_len;
    logic          ins_reading;
    logic          ins_beat_valid;
    logic          ins_done;

    logic          dat_read_req;
    logic [AW-1:0] dat_read_addr;
    logic [LW-1:0] dat_read_len;
    logic          dat_reading;
    logic          dat_beat_valid;
    logic          dat_done;

    logic [LW-1:0] beat_cnt;

    logic          ddr_rd_req;
    logic [AW-1:0] ddr_rd_addr;
    logic [LW-1:0] ddr_rd_len;
    logic          ddr_rd_ack;
    logic          ddr_rd_data_valid;
    logic          ddr_rd_finish;

    logic          err_len;

    modport slave (
        input  ins_read_req, ins_read_addr, ins_read_len,
        output ins_reading, ins_beat_valid, ins_done,
        input  dat_read_req, dat_read_addr, dat_read_len,
        output dat_reading, dat_beat_valid, dat_done,
        output beat_cnt,
        output ddr_rd_req, ddr_rd_addr, ddr_rd_len,
        input  ddr_rd_ack, ddr_rd_data_valid, ddr_rd_finish,
        output err_len
    );

    modport master (
        output ins_read_req, ins_read_addr, ins_read_len,
        input  ins_reading, ins_beat_valid, ins_done,
        output dat_read_req, dat_read_addr, dat_read_len,
        input  dat_reading, dat_beat_valid, dat_done,
        input  beat_cnt,
        input  ddr_rd_req, ddr_rd_addr, ddr_rd_len,
        output ddr_rd_ack, ddr_rd_data_valid, ddr_rd_finish,
        input  err_len
    );
endinterface

// File: rtl/ddr_rd_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker
// Ties go to the requester not granted last.
module ddr_rd_arbiter_rr_arb2
    import ddr_rd_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_ins_i,
    input  logic   req_dat_i,
    input  logic   upd_i,
    input  grant_e upd_grant_i,
    output logic   valid_o,
    output grant_e grant_o
);
    grant_e last_q;
    grant_e last_d;

    // remember the most recently served requester
    always_ff @(posedge clk) begin
        if (rst) last_q <= GRANT_DAT;
        else     last_q <= last_d;
    end

    // pick and next last_grant
    always_comb begin
        last_d  = last_q;
        valid_o = req_ins_i | req_dat_i;
        grant_o = GRANT_INS;
        if (upd_i) last_d = upd_grant_i;
        if (req_ins_i && req_dat_i)
            grant_o = (last_q == GRANT_DAT) ? GRANT_INS : GRANT_DAT;
        else if (req_dat_i)
            grant_o = GRANT_DAT;
    end
endmodule

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: shares one DDR read-burst channel
// between the instruction and data caches.
module ddr_rd_arbiter
    import ddr_rd_arbiter_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = ddr_rd_arbiter_pkg::DDR_ADDR_WIDTH,
    parameter int LEN_WIDTH      = ddr_rd_arbiter_pkg::LEN_WIDTH
)(
    input logic             clk,
    input logic             rst,
    ddr_rd_arbiter_if.slave bus
);
    localparam int AW = DDR_ADDR_WIDTH;
    localparam int LW = LEN_WIDTH;

    state_e        state_q, state_d;
    grant_e        grant_q, grant_d;
    logic          reading_q, reading_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          finw_q, finw_d;

    logic          pick_valid;
    grant_e        pick;
    logic          upd;
    logic          fwd;
    logic          fin;
    logic [LW-1:0] rcv;
    logic [LW-1:0] sel_len;

    ddr_rd_arbiter_rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .req_ins_i   (bus.ins_read_req),
        .req_dat_i   (bus.dat_read_req),
        .upd_i       (upd),
        .upd_grant_i (grant_q),
        .valid_o     (pick_valid),
        .grant_o     (pick)
    );

    // finw_q: burst closed on its last beat before the DDR
    // finish pulse; beats until finish are surplus and dropped
    assign fwd = (state_q == BURST) & bus.ddr_rd_data_valid & ~finw_q;
    assign fin = bus.ddr_rd_finish & ~finw_q;
    assign rcv = cnt_q + LW'(fwd);
    assign sel_len = (pick == GRANT_INS) ? bus.ins_read_len
                                         : bus.dat_read_len;

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= GRANT_INS;
            reading_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            finw_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            reading_q <= reading_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            finw_q    <= finw_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        reading_d = reading_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        finw_d    = finw_q;
        upd       = 1'b0;
        if (finw_q) begin
            if (bus.ddr_rd_data_valid) err_d  = 1'b1;
            if (bus.ddr_rd_finish)     finw_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d   = pick;
                    reading_d = 1'b1;
                    addr_d    = (pick == GRANT_INS) ? bus.ins_read_addr
                                                    : bus.dat_read_addr;
                    len_d     = sel_len;
                    state_d   = (sel_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (bus.ddr_rd_ack) begin
                    state_d = BURST;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (fwd) cnt_d = cnt_q + 1'b1;
                if (fin) begin
                    state_d = DONE;
                    if (rcv != len_q) err_d = 1'b1;
                end else if (fwd && (cnt_q == len_q - 1'b1)) begin
                    state_d = DONE;
                    finw_d  = 1'b1;
                end
            end
            DONE: begin
                reading_d = 1'b0;
                upd       = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    assign bus.ins_reading    = reading_q & (grant_q == GRANT_INS);
    assign bus.dat_reading    = reading_q & (grant_q == GRANT_DAT);
    assign bus.ins_beat_valid = fwd & (grant_q == GRANT_INS);
    assign bus.dat_beat_valid = fwd & (grant_q == GRANT_DAT);
    assign bus.ins_done = (state_q == DONE) & (grant_q == GRANT_INS);
    assign bus.dat_done = (state_q == DONE) & (grant_q == GRANT_DAT);
    assign bus.beat_cnt    = fwd ? cnt_q : '0;
    assign bus.ddr_rd_req  = (state_q == ISSUE);
    assign bus.ddr_rd_addr = addr_q;
    assign bus.ddr_rd_len  = len_q;
    assign bus.err_len     = err_q;
endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: directed self-checking bench
// Inputs change 1ns after posedge, checks 1ns later.
module tb_ddr_rd_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ddr_rd_arbiter_if bus ();

    ddr_rd_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] all_out();
        return {20'd0, bus.ins_reading, bus.dat_reading,
                bus.ins_beat_valid, bus.dat_beat_valid,
                bus.ins_done, bus.dat_done, bus.ddr_rd_req,
                bus.err_len, |bus.ddr_rd_addr, |bus.ddr_rd_len,
                |bus.beat_cnt, 1'b0};
    endfunction

    task automatic ack();
        bus.ddr_rd_ack = 1'b1;
        cyc();
        bus.ddr_rd_ack = 1'b0;
    endtask

    initial begin
        bus.ins_read_req      = 1'b0;
        bus.ins_read_addr     = '0;
        bus.ins_read_len      = '0;
        bus.dat_read_req      = 1'b0;
        bus.dat_read_addr     = '0;
        bus.dat_read_len      = '0;
        bus.ddr_rd_ack        = 1'b0;
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b0;
        cyc();
        cyc();
        settle();
        chk("reset_outs", all_out(), 32'd0);
        rst = 1'b0;

        // single ins burst, len 4
        cyc();
        bus.ins_read_req  = 1'b1;
        bus.ins_read_addr = 28'h100;
        bus.ins_read_len  = 8'd4;
        cyc();
        bus.ins_read_req = 1'b0;
        settle();
        chk("t1_reading", bus.ins_reading, 1);
        chk("t1_req", bus.ddr_rd_req, 1);
        chk("t1_addr", bus.ddr_rd_addr, 32'h100);
        chk("t1_len", bus.ddr_rd_len, 4);
        cyc();
        chk("t1_req_hold", bus.ddr_rd_req, 1);
        ack();
        settle();
        chk("t1_req_drop", bus.ddr_rd_req, 0);
        for (int i = 0; i < 4; i++) begin
            bus.ddr_rd_data_valid = 1'b1;
            bus.ddr_rd_finish     = (i == 3);
            settle();
            chk("t1_bv", bus.ins_beat_valid, 1);
            chk("t1_dbv", bus.dat_beat_valid, 0);
            chk("t1_cnt", bus.beat_cnt, i);
            cyc();
        end
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b0;
        settle();
        chk("t1_done", bus.ins_done, 1);
        chk("t1_rd_in_done", bus.ins_reading, 1);
        cyc();
        chk("t1_done_pulse", bus.ins_done, 0);
        chk("t1_rd_clr", bus.ins_reading, 0);
        chk("t1_err", bus.err_len, 0);

        // tie after reset: ins first, then dat, then ins
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.ins_read_req  = 1'b1;
        bus.ins_read_addr = 28'h200;
        bus.ins_read_len  = 8'd1;
        bus.dat_read_req  = 1'b1;
        bus.dat_read_addr = 28'h300;
        bus.dat_read_len  = 8'd2;
        cyc();
        settle();
        chk("t2_ins_rd", bus.ins_reading, 1);
        chk("t2_dat_rd", bus.dat_reading, 0);
        chk("t2_addr_i", bus.ddr_rd_addr, 32'h200);
        ack();
        bus.ddr_rd_data_valid = 1'b1;
        bus.ddr_rd_finish     = 1'b1;
        settle();
        chk("t2_ibv", bus.ins_beat_valid, 1);
        cyc();
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b0;
        settle();
        chk("t2_idone", bus.ins_done, 1);
        bus.ins_read_req = 1'b0;
        cyc();
        chk("t2_gap_req", bus.ddr_rd_req, 0);
        chk("t2_gap_rd", bus.dat_reading, 0);
        cyc();
        chk("t2_dat_rd2", bus.dat_reading, 1);
        chk("t2_addr_d", bus.ddr_rd_addr, 32'h300);
        chk("t2_len_d", bus.ddr_rd_len, 2);
        ack();
        for (int i = 0; i < 2; i++) begin
            bus.ddr_rd_data_valid = 1'b1;
            bus.ddr_rd_finish     = (i == 1);
            settle();
            chk("t2_dbv", bus.dat_beat_valid, 1);
            chk("t2_dcnt", bus.beat_cnt, i);
            cyc();
        end
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b0;
        bus.ins_read_req  = 1'b1;
        bus.ins_read_addr = 28'h400;
        settle();
        chk("t2_ddone", bus.dat_done, 1);
        cyc();
        cyc();
        bus.ins_read_req = 1'b0;
        bus.dat_read_req = 1'b0;
        settle();
        chk("t2_rr_ins", bus.ins_reading, 1);
        chk("t2_rr_addr", bus.ddr_rd_addr, 32'h400);
        ack();
        bus.ddr_rd_data_valid = 1'b1;
        bus.ddr_rd_finish     = 1'b1;
        cyc();
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b0;
        cyc();

        // dat len 0 skips DDR
        bus.dat_read_req  = 1'b1;
        bus.dat_read_addr = 28'h500;
        bus.dat_read_len  = 8'd0;
        cyc();
        bus.dat_read_req = 1'b0;
        settle();
        chk("t3_rd", bus.dat_reading, 1);
        chk("t3_done", bus.dat_done, 1);
        chk("t3_noreq", bus.ddr_rd_req, 0);
        cyc();
        chk("t3_rd_clr", bus.dat_reading, 0);
        chk("t3_done_clr", bus.dat_done, 0);
        chk("t3_noreq2", bus.ddr_rd_req, 0);

        // early finish: len 3, finish on 2nd beat
        bus.dat_read_req  = 1'b1;
        bus.dat_read_addr = 28'h600;
        bus.dat_read_len  = 8'd3;
        cyc();
        bus.dat_read_req = 1'b0;
        cyc();
        ack();
        bus.ddr_rd_data_valid = 1'b1;
        cyc();
        bus.ddr_rd_finish = 1'b1;
        settle();
        chk("t4_bv1", bus.dat_beat_valid, 1);
        chk("t4_cnt1", bus.beat_cnt, 1);
        cyc();
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b0;
        settle();
        chk("t4_done", bus.dat_done, 1);
        chk("t4_err", bus.err_len, 1);
        cyc();
        chk("t4_err_sticky", bus.err_len, 1);

        // surplus beat: len 2, 3 beats then finish
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        chk("t4b_err_rst", bus.err_len, 0);
        bus.ins_read_req  = 1'b1;
        bus.ins_read_addr = 28'h700;
        bus.ins_read_len  = 8'd2;
        cyc();
        bus.ins_read_req = 1'b0;
        ack();
        bus.ddr_rd_data_valid = 1'b1;
        cyc();
        cyc();
        settle();
        chk("t4b_extra_bv", bus.ins_beat_valid, 0);
        chk("t4b_done", bus.ins_done, 1);
        chk("t4b_err_pre", bus.err_len, 0);
        cyc();
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b1;
        settle();
        chk("t4b_err", bus.err_len, 1);
        cyc();
        bus.ddr_rd_finish = 1'b0;

        // reset during burst
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.dat_read_req  = 1'b1;
        bus.dat_read_addr = 28'h800;
        bus.dat_read_len  = 8'd8;
        cyc();
        bus.dat_read_req = 1'b0;
        ack();
        bus.ddr_rd_data_valid = 1'b1;
        settle();
        chk("t5_bv0", bus.dat_beat_valid, 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        chk("t5_outs", all_out(), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_drop", bus.dat_beat_valid, 0);
        end
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b1;
        cyc();
        bus.ddr_rd_finish = 1'b0;
        bus.ins_read_req  = 1'b1;
        bus.ins_read_addr = 28'h900;
        bus.ins_read_len  = 8'd1;
        cyc();
        bus.ins_read_req = 1'b0;
        settle();
        chk("t5_new_addr", bus.ddr_rd_addr, 32'h900);
        ack();
        bus.ddr_rd_data_valid = 1'b1;
        bus.ddr_rd_finish     = 1'b1;
        settle();
        chk("t5_new_bv", bus.ins_beat_valid, 1);
        cyc();
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b0;
        settle();
        chk("t5_new_done", bus.ins_done, 1);
        cyc();

        // len 255, no wrap
        bus.dat_read_req  = 1'b1;
        bus.dat_read_addr = 28'hABC0;
        bus.dat_read_len  = 8'd255;
        cyc();
        bus.dat_read_req = 1'b0;
        ack();
        for (int i = 0; i < 255; i++) begin
            bus.ddr_rd_data_valid = 1'b1;
            bus.ddr_rd_finish     = (i == 254);
            settle();
            chk("t6_cnt", {bus.dat_beat_valid, 23'd0, bus.beat_cnt},
                {1'b1, 23'd0, 8'(i)});
            chk("t6_early_done", bus.dat_done, 0);
            cyc();
        end
        bus.ddr_rd_data_valid = 1'b0;
        bus.ddr_rd_finish     = 1'b0;
        settle();
        chk("t6_done", bus.dat_done, 1);
        chk("t6_err", bus.err_len, 0);
        cyc();
        chk("t6_rd_clr", bus.dat_reading, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
